// File: rtl/mem_responder_if.sv
// mem_responder_if: request/response bus between the datapath (master) and the memory responder (slave).
interface mem_responder_if #(parameter int ADDR_WIDTH = 32);
  logic                  mem_cs;
  logic                  mem_write_en;
  logic                  mem_read;
  logic [1:0]            size;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [63:0]           mem_wdata;
  logic [63:0]           mem_rdata;
  logic                  mem_ready;
  logic                  mem_error;
  logic                  busy;
  modport master (
    output mem_cs, mem_write_en, mem_read, size, mem_address, mem_wdata,
    input  mem_rdata, mem_ready, mem_error, busy
  );
  modport slave (
    input  mem_cs, mem_write_en, mem_read, size, mem_address, mem_wdata,
    output mem_rdata, mem_ready, mem_error, busy
  );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: latches one request, waits WAIT_CYCLES, then does a sized access to a 64-bit store.
// Optional MEM_RESP_ERR_COUNT_EN adds a saturating 8-bit rejected-request counter (err_count).
module mem_responder #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  mem_responder_if.slave       bus
`ifdef MEM_RESP_ERR_COUNT_EN
  ,
  output logic [7:0]           err_count
`endif
);
  localparam int IW = $clog2(DEPTH_WORDS);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t                state, state_n;
  logic [3:0]            cnt;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [1:0]            a_size;
  logic [63:0]           a_wdata;
  logic                  a_rd, a_wr;
  logic [63:0]           rdata;
  logic                  err_q;
  logic [63:0]           mem [DEPTH_WORDS];
  logic [2:0]            off, align;
  logic [5:0]            sh;
  logic [7:0]            lanes;
  logic [63:0]           size_mask, cur, new_word, rd_val;
  logic                  mis, oor, err, exec;
  logic [IW-1:0]         idx;
  always_comb begin
    state_n = state == IDLE ? (bus.mem_cs ? WAIT : IDLE)
            : state == WAIT ? (cnt == 4'd0 ? RESP : WAIT)
            : IDLE;
  end
  always_comb begin
    idx   = a_addr[3+IW-1:3];
    off   = a_addr[2:0];
    sh    = {off, 3'b000};
    lanes = a_size == 2'd0 ? 8'h01 : a_size == 2'd1 ? 8'h03 : a_size == 2'd2 ? 8'h0F : 8'hFF;
    align = a_size == 2'd0 ? 3'd0 : a_size == 2'd1 ? 3'd1 : a_size == 2'd2 ? 3'd3 : 3'd7;
    size_mask = '0;
    for (int i = 0; i < 8; i++) size_mask[i*8 +: 8] = {8{lanes[i]}};
    cur      = mem[idx];
    new_word = (cur & ~(size_mask << sh)) | ((a_wdata & size_mask) << sh);
    rd_val   = (cur >> sh) & size_mask;
    mis      = |(off & align);
    oor      = |(a_addr >> (3 + IW));
    err      = (a_rd == a_wr) | mis | oor;
    exec     = state == WAIT && cnt == 4'd0;
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      rdata <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && bus.mem_cs) begin
        cnt     <= 4'(WAIT_CYCLES);
        a_addr  <= bus.mem_address;
        a_size  <= bus.size;
        a_wdata <= bus.mem_wdata;
        a_rd    <= bus.mem_read;
        a_wr    <= bus.mem_write_en;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (exec) begin
        err_q <= err;
        if (!err && a_rd) rdata <= rd_val;
      end
    end
  end
  // Storage is never reset; a reset at the execute edge suppresses the write.
  always_ff @(posedge clock) begin
    if (reset && exec && !err && a_wr) mem[idx] <= new_word;
  end
`ifdef MEM_RESP_ERR_COUNT_EN
  always_ff @(posedge clock) begin
    if (!reset) err_count <= '0;
    else if (exec && err && err_count != 8'hFF) err_count <= err_count + 8'd1;
  end
`endif
  assign bus.mem_rdata = rdata;
  assign bus.mem_ready = state == RESP;
  assign bus.mem_error = state == RESP && err_q;
  assign bus.busy      = state != IDLE;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed checks of latency, sized read/write, error rejection, reset and back-to-back requests.
module tb_mem_responder;
  localparam int WAIT_CYCLES = 2;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   last_lat;
  logic last_err;
  logic [63:0] last_rdata;
  int   acc1, acc2, busy_n;
  logic prev_busy;
  mem_responder_if #(.ADDR_WIDTH(32)) bus ();
`ifdef MEM_RESP_ERR_COUNT_EN
  logic [7:0] err_count;
`endif
  mem_responder #(.ADDR_WIDTH(32), .DEPTH_WORDS(256), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
`ifdef MEM_RESP_ERR_COUNT_EN
    ,
    .err_count(err_count)
`endif
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // Issue one request from IDLE, wait for mem_ready (bounded), then step back into IDLE.
  task automatic req(input logic rd, input logic wr, input logic [1:0] sz,
                     input logic [31:0] a, input logic [63:0] wd);
    @(negedge clock);
    bus.mem_cs = 1'b1; bus.mem_read = rd; bus.mem_write_en = wr;
    bus.size = sz; bus.mem_address = a; bus.mem_wdata = wd;
    @(posedge clock); #1;
    bus.mem_cs = 1'b0; bus.mem_read = 1'b0; bus.mem_write_en = 1'b0;
    last_lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clock); #1;
      if (bus.mem_ready) begin
        last_lat = k;
        break;
      end
    end
    if (last_lat < 0) chk("ready_timeout", 64'd0, 64'd1);
    last_err   = bus.mem_error;
    last_rdata = bus.mem_rdata;
    @(posedge clock); #1;
  endtask
  initial begin
    bus.mem_cs = 1'b0; bus.mem_read = 1'b0; bus.mem_write_en = 1'b0;
    bus.size = 2'd0; bus.mem_address = '0; bus.mem_wdata = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_ready", 64'(bus.mem_ready), 64'd0);
    chk("rst_error", 64'(bus.mem_error), 64'd0);
    chk("rst_rdata", bus.mem_rdata, 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    @(negedge clock); reset = 1'b1;
    req(1'b0, 1'b1, 2'd0, 32'h10, 64'h5A);
    chk("wr10_err", 64'(last_err), 64'd0);
    chk("wr10_lat", 64'(last_lat), 64'(WAIT_CYCLES + 1));
    // Write interrupted by reset mid-WAIT must never land.
    @(negedge clock);
    bus.mem_cs = 1'b1; bus.mem_read = 1'b0; bus.mem_write_en = 1'b1;
    bus.size = 2'd0; bus.mem_address = 32'h10; bus.mem_wdata = 64'hAB;
    @(posedge clock); #1;
    bus.mem_cs = 1'b0; bus.mem_write_en = 1'b0;
    @(posedge clock); #1;
    chk("midwait_busy", 64'(bus.busy), 64'd1);
    @(negedge clock); reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst2_ready", 64'(bus.mem_ready), 64'd0);
    chk("rst2_error", 64'(bus.mem_error), 64'd0);
    chk("rst2_rdata", bus.mem_rdata, 64'd0);
    chk("rst2_busy", 64'(bus.busy), 64'd0);
    @(negedge clock); reset = 1'b1;
    req(1'b1, 1'b0, 2'd0, 32'h10, 64'd0);
    chk("rd10_rdata", last_rdata, 64'h5A);
    chk("rd10_err", 64'(last_err), 64'd0);
    req(1'b0, 1'b1, 2'd3, 32'h08, 64'h1122334455667788);
    chk("wrd08_err", 64'(last_err), 64'd0);
    req(1'b1, 1'b0, 2'd0, 32'h0B, 64'd0);
    chk("rb0B_rdata", last_rdata, 64'h55);
    chk("rb0B_err", 64'(last_err), 64'd0);
    chk("rb0B_lat", 64'(last_lat), 64'(WAIT_CYCLES + 1));
    req(1'b0, 1'b1, 2'd1, 32'h0C, 64'hFFFF_FFFF_FFFF_BEEF);
    chk("wh0C_err", 64'(last_err), 64'd0);
    req(1'b1, 1'b0, 2'd3, 32'h08, 64'd0);
    chk("rd08_rdata", last_rdata, 64'h1122BEEF55667788);
    req(1'b1, 1'b0, 2'd2, 32'h0C, 64'd0);
    chk("rw0C_rdata", last_rdata, 64'h1122BEEF);
    req(1'b1, 1'b0, 2'd3, 32'h08, 64'd0);
    req(1'b1, 1'b0, 2'd2, 32'h0A, 64'd0);
    chk("mis_err", 64'(last_err), 64'd1);
    chk("mis_rdata", last_rdata, 64'h1122BEEF55667788);
    req(1'b1, 1'b1, 2'd3, 32'h08, 64'd0);
    chk("rdwr_err", 64'(last_err), 64'd1);
    req(1'b0, 1'b0, 2'd0, 32'h08, 64'd0);
    chk("none_err", 64'(last_err), 64'd1);
    req(1'b1, 1'b0, 2'd3, 32'h08, 64'd0);
    chk("rdwr_keep", last_rdata, 64'h1122BEEF55667788);
    req(1'b0, 1'b1, 2'd3, 32'h00, 64'hCAFE);
    req(1'b0, 1'b1, 2'd3, 32'h800, 64'hDEAD);
    chk("oor_err", 64'(last_err), 64'd1);
    req(1'b1, 1'b0, 2'd3, 32'h00, 64'd0);
    chk("oor_keep", last_rdata, 64'hCAFE);
    chk("oor_keep_err", 64'(last_err), 64'd0);
    // mem_cs held high: second read accepted at first IDLE edge after RESP.
    req(1'b0, 1'b1, 2'd1, 32'h06, 64'h1234);
    @(negedge clock);
    bus.mem_cs = 1'b1; bus.mem_read = 1'b1; bus.mem_write_en = 1'b0;
    bus.size = 2'd1; bus.mem_address = 32'h06;
    acc1 = 0; acc2 = 0; busy_n = 0; prev_busy = 1'b0;
    for (int i = 1; i <= 2 * WAIT_CYCLES + 5; i++) begin
      @(posedge clock); #1;
      if (bus.busy && !prev_busy) begin
        if (acc1 == 0) acc1 = i;
        else acc2 = i;
      end
      if (bus.busy) busy_n++;
      prev_busy = bus.busy;
    end
    bus.mem_cs = 1'b0; bus.mem_read = 1'b0;
    chk("b2b_ready", 64'(bus.mem_ready), 64'd1);
    chk("b2b_rdata", bus.mem_rdata, 64'h1234);
    @(posedge clock); #1;
    chk("b2b_acc1", 64'(acc1), 64'd1);
    chk("b2b_acc2", 64'(acc2), 64'(WAIT_CYCLES + 4));
    chk("b2b_busy", 64'(busy_n), 64'(2 * (WAIT_CYCLES + 2)));
    chk("b2b_idle", 64'(bus.busy), 64'd0);
`ifdef MEM_RESP_ERR_COUNT_EN
    for (int n = 0; n < 300; n++) req(1'b1, 1'b0, 2'd2, 32'h0A, 64'd0);
    chk("errcnt_sat", 64'(err_count), 64'd255);
    @(negedge clock); reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("errcnt_rst", 64'(err_count), 64'd0);
    @(negedge clock); reset = 1'b1;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
